// File: rtl/femto_bus_pkg.sv
// Shared types and constants for the FemtoRV32 peripheral bus fabric.
package femto_bus_pkg;

    localparam int          TAG_W     = 16;
    localparam logic [31:0] ERR_RDATA = 32'h0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD    = 2'd1,
        ST_WR    = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

endpackage

// File: rtl/femto_addr_decoder.sv
// Priority window decoder: the lowest-index matching tag wins, otherwise the
// default slave is selected, or a miss is flagged when there is no valid default.
module femto_addr_decoder
    import femto_bus_pkg::*;
#(
    parameter int                       NSLAVES       = 4,
    parameter logic [NSLAVES*TAG_W-1:0] BASE          = '0,
    parameter int                       DEFAULT_SLAVE = 0
)(
    input  logic [TAG_W-1:0]   tag,
    output logic [NSLAVES-1:0] hit,
    output logic               miss
);

    logic found;

    always_comb begin
        hit   = '0;
        found = 1'b0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (!found && tag == BASE[TAG_W*i +: TAG_W]) begin
                hit[i] = 1'b1;
                found  = 1'b1;
            end
        end
        if (!found) begin
            for (int i = 0; i < NSLAVES; i++) begin
                if (i == DEFAULT_SLAVE) hit[i] = 1'b1;
            end
        end
        miss = !found && (DEFAULT_SLAVE >= NSLAVES);
    end

endmodule

// File: rtl/femto_bus_fabric.sv
// Memory-mapped interconnect between the FemtoRV32 core and its peripheral slaves:
// window decode, per-transaction slave latch, busy aggregation, watchdog, error log.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_IDLE  | no transaction pending, accept a strobe
//  ST_RD    | read pending, core busy mirrors the latched slave's rbusy
//  ST_WR    | write pending, core busy mirrors the latched slave's wbusy
//  ST_ABORT | one-cycle error completion: busy low, rdata forced to zero
module femto_bus_fabric
    import femto_bus_pkg::*;
#(
    parameter int                       NSLAVES       = 4,
    parameter int                       SEL_LO        = 16,
    parameter logic [NSLAVES*TAG_W-1:0] BASE          = {16'h0001, 16'h0040, 16'h0000, 16'h0000},
    parameter int                       DEFAULT_SLAVE = 0,
    parameter int                       TIMEOUT       = 1023
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             m_addr,
    input  logic [31:0]             m_wdata,
    input  logic [3:0]              m_wmask,
    input  logic                    m_rstrb,
    output logic [31:0]             m_rdata,
    output logic                    m_rbusy,
    output logic                    m_wbusy,
    output logic [NSLAVES-1:0]      s_rd,
    output logic [NSLAVES-1:0]      s_wr,
    input  logic [32*NSLAVES-1:0]   s_rdata,
    input  logic [NSLAVES-1:0]      s_rbusy,
    input  logic [NSLAVES-1:0]      s_wbusy,
    output logic                    err_flag,
    output logic [31:0]             err_addr,
    output logic [7:0]              err_count,
    input  logic                    err_clr
);

    localparam int IDX_W = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;

    state_t             state, state_nxt;
    logic [NSLAVES-1:0] hit;
    logic               miss;
    logic [IDX_W-1:0]   hit_idx, cur_idx;
    logic [31:0]        cur_addr;
    logic [TMR_W-1:0]   tmr;
    logic               wr_req, rd_req, any_req;
    logic               cur_rbusy, cur_wbusy;
    logic [31:0]        cur_rdata;
    logic               slave_busy, tmo, start, miss_err, err_evt;
    logic [31:0]        err_addr_new;

    // Slaves tap the write data bus directly; the fabric itself never inspects it.
    logic unused_wdata;
    assign unused_wdata = ^m_wdata;

    femto_addr_decoder #(
        .NSLAVES       (NSLAVES),
        .BASE          (BASE),
        .DEFAULT_SLAVE (DEFAULT_SLAVE)
    ) u_dec (
        .tag  (m_addr[SEL_LO+TAG_W-1:SEL_LO]),
        .hit  (hit),
        .miss (miss)
    );

    // A write in the same cycle as a read strobe suppresses the read.
    assign wr_req  = |m_wmask;
    assign rd_req  = m_rstrb & ~wr_req;
    assign any_req = wr_req | m_rstrb;

    assign s_rd = hit & {NSLAVES{rd_req & ~rst}};
    assign s_wr = hit & {NSLAVES{wr_req & ~rst}};

    always_comb begin
        hit_idx = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (hit[i]) hit_idx = IDX_W'(i);
        end
    end

    always_comb begin
        cur_rbusy = 1'b0;
        cur_wbusy = 1'b0;
        cur_rdata = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (cur_idx == IDX_W'(i)) begin
                cur_rbusy = s_rbusy[i];
                cur_wbusy = s_wbusy[i];
                cur_rdata = s_rdata[32*i +: 32];
            end
        end
    end

    assign slave_busy   = ((state == ST_RD) && cur_rbusy) || ((state == ST_WR) && cur_wbusy);
    assign tmo          = (TIMEOUT != 0) && slave_busy && (tmr == '0);
    assign start        = (state == ST_IDLE) && any_req && !miss;
    assign miss_err     = (state == ST_IDLE) && any_req && miss;
    assign err_evt      = miss_err || tmo;
    assign err_addr_new = miss_err ? m_addr : cur_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    if (miss)        state_nxt = ST_ABORT;
                    else if (wr_req) state_nxt = ST_WR;
                    else             state_nxt = ST_RD;
                end
            end
            ST_RD, ST_WR: begin
                if (tmo)             state_nxt = ST_ABORT;
                else if (!slave_busy) state_nxt = ST_IDLE;
            end
            ST_ABORT:                state_nxt = ST_IDLE;
            default:                 state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        m_rbusy = 1'b0;
        m_wbusy = 1'b0;
        m_rdata = cur_rdata;
        case (state)
            ST_RD:    m_rbusy = cur_rbusy;
            ST_WR:    m_wbusy = cur_wbusy;
            ST_ABORT: m_rdata = ERR_RDATA;
            default:  ;
        endcase
    end

    // Watchdog counts down from TIMEOUT-1; terminal count while still busy aborts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_idx  <= '0;
            cur_addr <= '0;
            tmr      <= '0;
        end else if (start) begin
            cur_idx  <= hit_idx;
            cur_addr <= m_addr;
            tmr      <= TMR_LOAD;
        end else if (slave_busy && tmr != '0) begin
            tmr      <= tmr - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_flag  <= 1'b0;
            err_addr  <= '0;
            err_count <= '0;
        end else if (err_evt) begin
            err_flag <= 1'b1;
            if (err_clr || !err_flag) err_addr <= err_addr_new;
            if (err_clr)                  err_count <= 8'd1;
            else if (err_count != 8'hFF)  err_count <= err_count + 8'd1;
        end else if (err_clr) begin
            err_flag  <= 1'b0;
            err_addr  <= '0;
            err_count <= '0;
        end
    end

endmodule

// File: tb/tb_femto_bus_fabric.sv
// Bench for femto_bus_fabric: reset, decode vector table, directed multi-cycle
// sequences, then randomized traffic against a transaction-level model.
module tb_femto_bus_fabric;

    localparam int          NS   = 3;
    localparam int          TMO  = 8;
    localparam logic [47:0] BASE_A = 48'h0001_0040_0000;
    localparam logic [47:0] BASE_B = 48'h0040_0040_0000;
    localparam logic [31:0] D0 = 32'hAAAA_0000;
    localparam logic [31:0] D1 = 32'hBBBB_1111;
    localparam logic [31:0] D2 = 32'hCCCC_2222;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic [3:0]  m_wmask = '0;
    logic        m_rstrb = 1'b0, err_clr = 1'b0;
    logic [95:0] s_rdata = '0;
    logic [2:0]  s_rbusy = '0, s_wbusy = '0;

    logic [31:0] m_rdata, err_addr;
    logic        m_rbusy, m_wbusy, err_flag;
    logic [2:0]  s_rd, s_wr;
    logic [7:0]  err_count;

    logic [31:0] unused_rdata_b, unused_eaddr_b;
    logic        unused_rbusy_b, m_wbusy_b, err_flag_b;
    logic [2:0]  s_rd_b, s_wr_b;
    logic [7:0]  unused_ecount_b;

    femto_bus_fabric #(
        .NSLAVES(NS), .SEL_LO(16), .BASE(BASE_A), .DEFAULT_SLAVE(3), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask),
        .m_rstrb(m_rstrb), .m_rdata(m_rdata), .m_rbusy(m_rbusy), .m_wbusy(m_wbusy),
        .s_rd(s_rd), .s_wr(s_wr), .s_rdata(s_rdata), .s_rbusy(s_rbusy), .s_wbusy(s_wbusy),
        .err_flag(err_flag), .err_addr(err_addr), .err_count(err_count), .err_clr(err_clr)
    );

    femto_bus_fabric #(
        .NSLAVES(NS), .SEL_LO(16), .BASE(BASE_B), .DEFAULT_SLAVE(0), .TIMEOUT(0)
    ) dut_b (
        .clk(clk), .rst(rst), .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask),
        .m_rstrb(m_rstrb), .m_rdata(unused_rdata_b), .m_rbusy(unused_rbusy_b), .m_wbusy(m_wbusy_b),
        .s_rd(s_rd_b), .s_wr(s_wr_b), .s_rdata(s_rdata), .s_rbusy(s_rbusy), .s_wbusy(s_wbusy),
        .err_flag(err_flag_b), .err_addr(unused_eaddr_b), .err_count(unused_ecount_b), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [15:0] tags_a [3] = '{16'h0000, 16'h0040, 16'h0001};
    logic [15:0] tags_b [3] = '{16'h0000, 16'h0040, 16'h0040};

    typedef struct packed {
        logic [31:0] addr;
        logic        rstrb;
        logic [3:0]  wmask;
        logic [2:0]  rd, wr, rd_b, wr_b;
        logic [31:0] rdata;
        logic        miss;
    } vec_t;
    vec_t vt [9];

    // transaction-level reference state
    int          act, waited, last_idx, ia, ib, e_cnt, exp_cnt;
    bit          act_wr, aborting, e_flag, err_now, req, wr, bsy, got_first;
    logic [31:0] act_addr, e_addr, new_ea, first_miss;

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act_v, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_rstrb = 1'b0;
        m_wmask = 4'h0;
        err_clr = 1'b0;
    endtask

    function automatic int decode(input logic [31:0] addr, input bit use_b);
        for (int i = 0; i < NS; i++) begin
            if (addr[31:16] == (use_b ? tags_b[i] : tags_a[i])) return i;
        end
        return use_b ? 0 : -1;
    endfunction

    function automatic logic [2:0] oh(input int idx, input bit en);
        if (!en || idx < 0) return 3'b000;
        return 3'(1 << idx);
    endfunction

    function automatic logic [31:0] sd(input int i);
        return s_rdata[32*i +: 32];
    endfunction

    initial begin
        vt[0] = '{32'h0040_0004, 1'b1, 4'h0, 3'b010, 3'b000, 3'b010, 3'b000, D1, 1'b0};
        vt[1] = '{32'h0000_1000, 1'b1, 4'h0, 3'b001, 3'b000, 3'b001, 3'b000, D0, 1'b0};
        vt[2] = '{32'h0001_FFFC, 1'b0, 4'hF, 3'b000, 3'b100, 3'b000, 3'b001, D2, 1'b0};
        vt[3] = '{32'h1234_0000, 1'b1, 4'h0, 3'b000, 3'b000, 3'b001, 3'b000, 32'h0, 1'b1};
        vt[4] = '{32'h0040_0000, 1'b1, 4'h1, 3'b000, 3'b010, 3'b000, 3'b010, D1, 1'b0};
        vt[5] = '{32'h0041_0040, 1'b1, 4'h0, 3'b000, 3'b000, 3'b001, 3'b000, 32'h0, 1'b1};
        vt[6] = '{32'h0000_0040, 1'b0, 4'h8, 3'b000, 3'b001, 3'b000, 3'b001, D0, 1'b0};
        vt[7] = '{32'h0040_0000, 1'b0, 4'h0, 3'b000, 3'b000, 3'b000, 3'b000, D0, 1'b0};
        vt[8] = '{32'hFFFF_0000, 1'b0, 4'h6, 3'b000, 3'b000, 3'b000, 3'b001, 32'h0, 1'b1};

        // reset held with random inputs
        for (int c = 0; c < 8; c++) begin
            tick();
            m_addr = $urandom; m_wdata = $urandom; m_wmask = 4'($urandom);
            m_rstrb = 1'($urandom); err_clr = 1'($urandom);
            s_rdata = {$urandom, $urandom, $urandom};
            s_rbusy = 3'($urandom); s_wbusy = 3'($urandom);
            @(negedge clk);
            chk("rst_rbusy", 32'(m_rbusy), 0);
            chk("rst_wbusy", 32'(m_wbusy), 0);
            chk("rst_s_rd", 32'(s_rd), 0);
            chk("rst_s_wr", 32'(s_wr), 0);
            chk("rst_err_flag", 32'(err_flag), 0);
            chk("rst_err_addr", err_addr, 0);
            chk("rst_err_count", 32'(err_count), 0);
        end
        tick();
        idle_inputs();
        s_rbusy = '0; s_wbusy = '0;
        s_rdata = {D2, D1, D0};
        rst = 1'b0;

        // decode vector table, zero-wait slaves
        exp_cnt = 0; got_first = 0; first_miss = '0;
        for (int i = 0; i < 9; i++) begin
            tick();
            m_addr = vt[i].addr; m_rstrb = vt[i].rstrb; m_wmask = vt[i].wmask;
            @(negedge clk);
            chk("vec_s_rd", 32'(s_rd), 32'(vt[i].rd));
            chk("vec_s_wr", 32'(s_wr), 32'(vt[i].wr));
            chk("vec_s_rd_b", 32'(s_rd_b), 32'(vt[i].rd_b));
            chk("vec_s_wr_b", 32'(s_wr_b), 32'(vt[i].wr_b));
            tick();
            idle_inputs();
            if (vt[i].miss) begin
                exp_cnt++;
                if (!got_first) begin first_miss = vt[i].addr; got_first = 1; end
            end
            @(negedge clk);
            chk("vec_rbusy", 32'(m_rbusy), 0);
            chk("vec_wbusy", 32'(m_wbusy), 0);
            chk("vec_rdata", m_rdata, vt[i].rdata);
            chk("vec_err_count", 32'(err_count), exp_cnt);
        end
        chk("vec_err_addr", err_addr, first_miss);
        chk("vec_err_flag", 32'(err_flag), 1);
        tick(); err_clr = 1'b1;
        tick(); err_clr = 1'b0;
        @(negedge clk);
        chk("clr_flag", 32'(err_flag), 0);
        chk("clr_count", 32'(err_count), 0);
        chk("clr_addr", err_addr, 0);

        // UART read, 3 busy cycles, address moves away while pending
        tick();
        m_addr = 32'h0040_0004; m_rstrb = 1'b1; s_rdata[63:32] = 32'h5A;
        @(negedge clk);
        chk("uart_s_rd", 32'(s_rd), 32'b010);
        chk("uart_rbusy_t", 32'(m_rbusy), 0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            idle_inputs();
            m_addr = 32'h0000_0000; s_rbusy = 3'b010;
            s_rdata[63:32] = 32'h100 + 32'(k); s_rdata[31:0] = 32'hDEAD_0000 + 32'(k);
            @(negedge clk);
            chk("uart_rbusy", 32'(m_rbusy), 1);
            chk("uart_track", m_rdata, 32'h100 + 32'(k));
        end
        tick();
        s_rbusy = '0; s_rdata[63:32] = 32'h5A;
        @(negedge clk);
        chk("uart_done_rbusy", 32'(m_rbusy), 0);
        chk("uart_rdata", m_rdata, 32'h5A);

        // watchdog: write to slave 2 stuck busy; dut_b (watchdog off) stalls on slave 0
        tick();
        m_addr = 32'h0001_0000; m_wmask = 4'hF; s_wbusy = 3'b101;
        @(negedge clk);
        chk("tmo_s_wr", 32'(s_wr), 32'b100);
        chk("tmo_s_wr_b", 32'(s_wr_b), 32'b001);
        for (int k = 1; k <= 20; k++) begin
            tick();
            idle_inputs();
            @(negedge clk);
            chk("tmo_wbusy", 32'(m_wbusy), (k <= TMO) ? 32'd1 : 32'd0);
            if (k == TMO + 1) begin
                chk("tmo_rdata", m_rdata, 0);
                chk("tmo_err_flag", 32'(err_flag), 1);
                chk("tmo_err_addr", err_addr, 32'h0001_0000);
                chk("tmo_err_count", 32'(err_count), 1);
            end
        end
        chk("nowdog_wbusy_b", 32'(m_wbusy_b), 1);
        tick(); s_wbusy = '0;
        tick();
        tick();
        m_addr = 32'h0001_0008; m_wmask = 4'h3; s_wbusy = 3'b101;
        for (int k = 1; k <= TMO + 1; k++) begin
            tick();
            idle_inputs();
        end
        @(negedge clk);
        chk("tmo2_wbusy", 32'(m_wbusy), 0);
        chk("tmo2_err_addr", err_addr, 32'h0001_0000);
        chk("tmo2_err_count", 32'(err_count), 2);
        tick(); s_wbusy = '0;
        tick();
        tick();

        // clear and new miss in the same cycle
        m_addr = 32'h7777_0000; m_rstrb = 1'b1; err_clr = 1'b1;
        @(negedge clk);
        chk("clrmiss_s_rd", 32'(s_rd), 0);
        tick();
        idle_inputs();
        @(negedge clk);
        chk("clrmiss_count", 32'(err_count), 1);
        chk("clrmiss_addr", err_addr, 32'h7777_0000);
        chk("clrmiss_flag", 32'(err_flag), 1);
        chk("clrmiss_rbusy", 32'(m_rbusy), 0);
        chk("clrmiss_rdata", m_rdata, 0);
        tick(); err_clr = 1'b1;
        tick(); err_clr = 1'b0;

        // error counter saturation
        for (int n = 0; n < 260; n++) begin
            tick();
            m_addr = 32'h8000_0000 | (32'(n) << 16); m_rstrb = 1'b1;
            tick();
            idle_inputs();
            @(negedge clk);
            chk("sat_count", 32'(err_count), (n + 1 > 255) ? 32'd255 : 32'(n + 1));
        end
        chk("sat_addr", err_addr, 32'h8000_0000);

        // reset in the middle of a pending read
        tick();
        m_addr = 32'h0040_0000; m_rstrb = 1'b1; s_rbusy = 3'b010;
        tick();
        idle_inputs();
        @(negedge clk);
        chk("mid_rbusy", 32'(m_rbusy), 1);
        tick();
        m_rstrb = 1'b1; m_wmask = 4'hF; rst = 1'b1;
        #1;
        chk("midrst_rbusy", 32'(m_rbusy), 0);
        chk("midrst_wbusy", 32'(m_wbusy), 0);
        chk("midrst_s_rd", 32'(s_rd), 0);
        chk("midrst_s_wr", 32'(s_wr), 0);
        chk("midrst_count", 32'(err_count), 0);
        chk("midrst_flag", 32'(err_flag), 0);
        tick();
        rst = 1'b0; idle_inputs(); s_rbusy = '0; s_rdata = {D2, D1, D0};
        tick();
        m_addr = 32'h0001_0000; m_rstrb = 1'b1;
        @(negedge clk);
        chk("post_s_rd", 32'(s_rd), 32'b100);
        tick();
        idle_inputs();
        @(negedge clk);
        chk("post_rbusy", 32'(m_rbusy), 0);
        chk("post_rdata", m_rdata, D2);

        // randomized traffic against the transaction model
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        act = -1; waited = 0; last_idx = 0; act_wr = 0; aborting = 0;
        act_addr = '0; e_flag = 0; e_cnt = 0; e_addr = '0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            case ($urandom_range(0, 3))
                0:       m_addr = {16'h0000, 16'($urandom)};
                1:       m_addr = {16'h0040, 16'($urandom)};
                2:       m_addr = {16'h0001, 16'($urandom)};
                default: m_addr = $urandom;
            endcase
            req = ($urandom_range(0, 99) < 35);
            m_rstrb = req && ($urandom_range(0, 1) == 1);
            m_wmask = (req && $urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            err_clr = ($urandom_range(0, 99) < 3);
            m_wdata = $urandom;
            s_rdata = {$urandom, $urandom, $urandom};
            for (int j = 0; j < NS; j++) begin
                s_rbusy[j] = ($urandom_range(0, 3) != 0);
                s_wbusy[j] = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            wr  = (m_wmask != 4'h0);
            req = m_rstrb || wr;
            ia  = decode(m_addr, 0);
            ib  = decode(m_addr, 1);
            chk("rnd_s_rd", 32'(s_rd), 32'(oh(ia, m_rstrb && !wr)));
            chk("rnd_s_wr", 32'(s_wr), 32'(oh(ia, wr)));
            chk("rnd_s_rd_b", 32'(s_rd_b), 32'(oh(ib, m_rstrb && !wr)));
            chk("rnd_s_wr_b", 32'(s_wr_b), 32'(oh(ib, wr)));
            chk("rnd_rbusy", 32'(m_rbusy), (act >= 0 && !act_wr) ? 32'(s_rbusy[act]) : 32'd0);
            chk("rnd_wbusy", 32'(m_wbusy), (act >= 0 && act_wr) ? 32'(s_wbusy[act]) : 32'd0);
            chk("rnd_rdata", m_rdata, aborting ? 32'd0 : sd(last_idx));
            chk("rnd_err_flag", 32'(err_flag), 32'(e_flag));
            chk("rnd_err_addr", err_addr, e_addr);
            chk("rnd_err_count", 32'(err_count), 32'(e_cnt));

            err_now = 0; new_ea = '0;
            if (aborting) begin
                aborting = 0;
            end else if (act >= 0) begin
                bsy = act_wr ? s_wbusy[act] : s_rbusy[act];
                if (!bsy) begin
                    act = -1;
                end else begin
                    waited++;
                    if (waited == TMO) begin
                        err_now = 1; new_ea = act_addr; act = -1; aborting = 1;
                    end
                end
            end else if (req) begin
                if (ia < 0) begin
                    err_now = 1; new_ea = m_addr; aborting = 1;
                end else begin
                    act = ia; act_wr = wr; waited = 0; act_addr = m_addr; last_idx = ia;
                end
            end
            if (err_now) begin
                if (err_clr) begin
                    e_cnt = 1; e_addr = new_ea;
                end else begin
                    if (!e_flag) e_addr = new_ea;
                    if (e_cnt < 255) e_cnt++;
                end
                e_flag = 1;
            end else if (err_clr) begin
                e_flag = 0; e_cnt = 0; e_addr = '0;
            end
        end
        chk("rnd_b_no_errors", 32'(err_flag_b), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/femto_bus_fabric.md
# femto_bus_fabric

Parametrised memory-mapped interconnect between the FemtoRV32 core and its N peripheral slaves (SPI flash, SPI RAM, UART, …), replacing the hand-written chip-select case statement and read-data mux in the top level. Each core access is decoded against a parameter table of 16-bit address windows. The fabric latches the selected slave for the whole transaction and aggregates busy handshakes. A watchdog aborts a stalled slave, and unmapped or timed-out accesses are recorded in an error/status port.

## Interface
Parameters:
- `NSLAVES`, 4: number of slave channels (1..16).
- `SEL_LO`, 16: LSB of the 16-bit decoded address field. The field is `m_addr[SEL_LO+15:SEL_LO]`.
- `BASE`, {16'h0001,16'h0040,16'h0000,16'h0000}: packed `NSLAVES*16` window tags. Slave i is selected by `BASE[16*i+:16]`.
- `DEFAULT_SLAVE`, 0: slave index used for unmatched addresses. A value ≥ `NSLAVES` means an unmatched address is an error.
- `TIMEOUT`, 1023: maximum busy cycles before abort. 0 disables the watchdog.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `m_addr`, in, 32: core address.
- `m_wdata`, in, 32: core write data, broadcast to all slaves.
- `m_wmask`, in, 4: byte write mask. Nonzero means write.
- `m_rstrb`, in, 1: one-cycle read strobe.
- `m_rdata`, out, 32: read data.
- `m_rbusy`, out, 1: read busy.
- `m_wbusy`, out, 1: write busy.
- `s_rd`, out, NSLAVES: per-slave read strobe.
- `s_wr`, out, NSLAVES: per-slave write strobe.
- `s_rdata`, in, 32*NSLAVES: packed slave read data.
- `s_rbusy`, in, NSLAVES: per-slave read busy.
- `s_wbusy`, in, NSLAVES: per-slave write busy.
- `err_flag`, out, 1: sticky error. Set on an unmapped or timed-out access.
- `err_addr`, out, 32: address of the first error since the last clear.
- `err_count`, out, 8: saturating error counter.
- `err_clr`, in, 1: clears `err_flag`, `err_addr` and `err_count`.

## Operation
- Decode is combinational.
  - The lowest index i with a matching tag wins.
  - With no match, the `DEFAULT_SLAVE` window is selected, or a miss if `DEFAULT_SLAVE` ≥ `NSLAVES`.
- Strobes pass through with zero latency: `s_rd[i] = m_rstrb & hit_i` and `s_wr[i] = |m_wmask & hit_i`.
- If `m_rstrb` and a write occur in the same cycle, the write wins and the read strobe is dropped.
- State machine: `IDLE`, `RD`, `WR`, `ABORT`.
  - `IDLE`:
    - strobe to a hit: latch `cur_idx`, go to `RD` or `WR`.
    - strobe to a miss: go to `ABORT` and log the error.
  - `RD` / `WR`:
    - `m_rbusy` / `m_wbusy` follow `s_rbusy[cur_idx]` / `s_wbusy[cur_idx]`.
    - Return to `IDLE` on the first cycle after entry in which the slave busy is low.
    - Timer increments each busy cycle. When it reaches `TIMEOUT`, go to `ABORT` and log the error.
  - `ABORT`: busy outputs are 0 and `m_rdata` is 0 for one cycle, then `IDLE`.
- `m_rdata` is `s_rdata[cur_idx]`, selected by the latched index, not the live address. It is 0 in `ABORT`.
- Error logging:
  - `err_flag` is set on each error.
  - `err_addr` is captured only when `err_flag` was 0.
  - `err_count` increments, saturating at 255.
  - If `err_clr` and a new error occur in the same cycle, the new error wins: flag = 1, count = 1, addr = new.
- A strobe arriving in `RD`/`WR` is a protocol violation. It is forwarded to the slave but does not change `cur_idx`.

## Timing
- Reset values: state `IDLE`, `cur_idx` 0, timer 0, `err_flag` 0, `err_addr` 0, `err_count` 0.
  - `m_rbusy`, `m_wbusy`, `s_rd` and `s_wr` are 0 while `rst` is high.
- Strobe cycle T:
  - slave strobe at T;
  - fabric busy can first be asserted at T+1.
- Data is valid in the first cycle after T in which `m_rbusy` is 0.
- A zero-wait slave (busy never asserted) completes at T+1.
- Timeout: with `TIMEOUT`=N and the slave stuck busy, `ABORT` is entered at T+N+1. The core sees busy low at T+N+1.
- A miss completes at T+1 with rdata 0, and `err_flag` is high from T+1.
- Reset asserted mid-transaction forces `IDLE` immediately. The slaves are reset by the same `rst`.

## Structure
- Package `femto_bus_pkg`: state enum, `ERR_RDATA` = 32'h0, tag width constant 16.
- Sub-module `femto_addr_decoder`: parameter-driven priority match. Outputs a one-hot `hit` and a `miss` flag.
- The top level instantiates one fabric with `NSLAVES`=3 and tags {0001, 0040, 0000}, default slave 0 (flash).

## Test plan
- Reset: hold `rst` with random inputs → all outputs at reset values, no `s_rd`/`s_wr` pulses.
- Read from UART (addr 0x0040_0004), slave busy 3 cycles, `s_rdata[1]`=0x5A → `s_rd`=3'b010 at T, `m_rbusy` high for T+1..T+3, `m_rdata`=0x5A at T+4.
- Address changes to 0x0000_0000 while a read from slave 1 is pending → `m_rdata` still tracks `s_rdata[1]` until completion.
- `DEFAULT_SLAVE`=NSLAVES, read from 0x1234_0000 → no slave strobe; busy 0 and rdata 0 at T+1; `err_flag`=1, `err_addr`=0x1234_0000, `err_count`=1.
- `TIMEOUT`=8, write to slave 2 with `s_wbusy[2]` stuck high → `m_wbusy` drops at T+9, error logged; a second error leaves `err_addr` unchanged and sets `err_count`=2.
- `err_clr` asserted in the same cycle as a new miss → `err_count`=1, `err_addr`=new address.
